// File: rtl/sigmoid_lut_writer.sv
// sigmoid_lut_writer: loads a LUT from a valid/ready stream, then (when VERIFY
// is set) reads the whole table back and compares a modulo-2**DATA_W checksum
// of the readback against the checksum of the written words.
//
// Cycle numbering: start_i is sampled high on the rising edge that closes
// cycle 0. The FSM is in LOAD from cycle 1.
//
// Timing with VERIFY=1, DEPTH = 2**ADDR_W and s_valid_i held high:
//   - Words transfer on the edges that close cycles 1..DEPTH.
//   - Writes are presented in cycles 2..DEPTH+1.
//   - Reads are presented in cycles DEPTH+2..2*DEPTH+1.
//   - DRAIN covers 2*DEPTH+1..2*DEPTH+2, and CHECK is cycle 2*DEPTH+3.
//   - FINISH is cycle 2*DEPTH+4, so done_o is high in cycle 2*DEPTH+4.
//
// Timing with VERIFY=0:
//   - The FSM passes through the same two-cycle DRAIN after the last write.
//   - done_o rises two cycles after the final write is presented
//     (cycle DEPTH+3 with no stalls).
module sigmoid_lut_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int VERIFY = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] di,
  input  logic [DATA_W-1:0] dout,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    DRAIN,
    CHECK,
    FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W-1:0]   rd_ptr_reg;
  logic [DATA_W-1:0]   sum_w_reg;
  logic [DATA_W-1:0]   sum_r_reg;
  logic                cap_reg;       // dout carries read data this cycle
  logic                drain_cnt_reg; // second DRAIN cycle marker
  logic                s_ready_reg;
  logic                en_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   di_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;

  // Sequencer: FSM, LUT port registers, pointers and both checksums
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sum_w_reg     <= '0;
      sum_r_reg     <= '0;
      cap_reg       <= 1'b0;
      drain_cnt_reg <= 1'b0;
      s_ready_reg   <= 1'b0;
      en_reg        <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      di_reg        <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // LUT strobes and done are single-cycle unless re-asserted below;
      // addr and di hold their last value.
      en_reg   <= 1'b0;
      we_reg   <= 1'b0;
      done_reg <= 1'b0;

      // A read presented this cycle returns data on dout next cycle.
      cap_reg <= en_reg & ~we_reg;
      if (cap_reg) begin
        sum_r_reg <= sum_r_reg + dout;
      end

      case (state_reg)
        IDLE: begin
          if (start_i) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            sum_w_reg   <= '0;
            sum_r_reg   <= '0;
            err_reg     <= 1'b0;
            s_ready_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= LOAD;
          end
        end

        LOAD: begin
          // s_ready_reg is high throughout LOAD, so valid alone marks a transfer.
          if (s_valid_i) begin
            en_reg     <= 1'b1;
            we_reg     <= 1'b1;
            addr_reg   <= wr_ptr_reg;
            di_reg     <= s_data_i;
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            sum_w_reg  <= sum_w_reg + s_data_i;
            if (wr_ptr_reg == LAST_ADDR) begin
              s_ready_reg   <= 1'b0;
              drain_cnt_reg <= 1'b0;
              if (VERIFY != 0) begin
                state_reg <= READ;
              end else begin
                state_reg <= DRAIN;
              end
            end
          end
        end

        READ: begin
          // Back-to-back reads; the first one lands right after the last write.
          en_reg     <= 1'b1;
          addr_reg   <= rd_ptr_reg;
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
          if (rd_ptr_reg == LAST_ADDR) begin
            drain_cnt_reg <= 1'b0;
            state_reg     <= DRAIN;
          end
        end

        DRAIN: begin
          // Two cycles: the last read is presented, then its data is captured.
          if (drain_cnt_reg) begin
            if (VERIFY != 0) begin
              state_reg <= CHECK;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= FINISH;
            end
          end else begin
            drain_cnt_reg <= 1'b1;
          end
        end

        CHECK: begin
          err_reg   <= (sum_r_reg != sum_w_reg);
          done_reg  <= 1'b1;
          state_reg <= FINISH;
        end

        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign s_ready_o = s_ready_reg;
  assign en        = en_reg;
  assign we        = we_reg;
  assign addr      = addr_reg;
  assign di        = di_reg;
  assign busy_o    = busy_reg;
  assign done_o    = done_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_sigmoid_lut_writer.sv
// Testbench for sigmoid_lut_writer: a table of load scenarios run against a
// VERIFY=1 instance with a LUT model, plus a hand-written VERIFY=0 sequence.
`timescale 1ns/1ps
module tb_sigmoid_lut_writer;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_valid = 1'b0;
  logic          s_ready_o, en, we, busy_o, done_o, err_o;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout;

  logic          start0   = 1'b0;
  logic [DW-1:0] s_data0  = '0;
  logic          s_valid0 = 1'b0;
  logic          s_ready0, en0, we0, busy0, done0, err0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] di0;
  logic [DW-1:0] dout0;

  sigmoid_lut_writer #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .s_data_i(s_data),
    .s_valid_i(s_valid), .s_ready_o(s_ready_o), .en(en), .we(we),
    .addr(addr), .di(di), .dout(dout), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  sigmoid_lut_writer #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .s_data_i(s_data0),
    .s_valid_i(s_valid0), .s_ready_o(s_ready0), .en(en0), .we(we0),
    .addr(addr0), .di(di0), .dout(dout0), .busy_o(busy0), .done_o(done0),
    .err_o(err0)
  );

  // LUT models: synchronous RAM, optional bit-0 corruption at address 5.
  logic [DW-1:0] lut  [N];
  logic [DW-1:0] lut0 [N];
  bit corrupt_en = 1'b0;

  always @(posedge clk) begin
    if (en) begin
      if (we) lut[addr] <= di;
      else    dout <= lut[addr] ^ {{(DW-1){1'b0}}, (corrupt_en && addr == AW'(5))};
    end
  end

  always @(posedge clk) begin
    if (en0) begin
      if (we0) lut0[addr0] <= di0;
      else     dout0 <= lut0[addr0];
    end
  end

  // Reference stream for the current run and bus scoreboard counters.
  logic [DW-1:0] stream_q [N];
  int  wr_idx = 0, rd_idx = 0, wr_bad = 0, rd_bad = 0, gap_bad = 0, mix_bad = 0;
  int  wr0_cnt = 0, wr0_bad = 0, rd0_cnt = 0;
  bit  valid_prev = 1'b0;

  always @(negedge clk) begin
    if (en === 1'b1 && we === 1'b1) begin
      if (wr_idx >= N) wr_bad++;
      else if (addr !== AW'(wr_idx) || di !== stream_q[wr_idx]) wr_bad++;
      if (!valid_prev) gap_bad++;
      if (rd_idx != 0) mix_bad++;
      wr_idx++;
    end else if (en === 1'b1 && we === 1'b0) begin
      if (wr_idx != N) mix_bad++;
      if (rd_idx >= N || addr !== AW'(rd_idx)) rd_bad++;
      rd_idx++;
    end
    valid_prev = s_valid;
  end

  always @(negedge clk) begin
    if (en0 === 1'b1 && we0 === 1'b1) begin
      if (addr0 !== AW'(wr0_cnt) || di0 !== DW'(wr0_cnt)) wr0_bad++;
      wr0_cnt++;
    end else if (en0 === 1'b1 && we0 === 1'b0) begin
      rd0_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    mode;      // 0 ramp/valid high, 1 ramp/valid toggling, 2 random data+valid
    bit    corrupt;
    int    start_at;  // cycle of an extra start_i pulse, -1 none
    int    abort_at;  // reset after this many transfers, -1 none
    bit    exp_err;
    int    exp_lat;   // done_o cycle, -1 not checked
  } vec_t;

  vec_t tbl [7];

  // Runs one scenario on the VERIFY=1 instance; entered and left at posedge+2.
  task automatic run_case(input vec_t v);
    int cyc, idx, lat, ndone, lim, n_after;
    bit xfer, err_at_done;
    logic [DW-1:0] sum_ref, exp_sum_r, sumw, sumr;
    sum_ref = '0;
    for (int i = 0; i < N; i++) begin
      stream_q[i] = (v.mode == 2) ? DW'($urandom) : DW'(i);
      sum_ref += stream_q[i];
    end
    exp_sum_r = v.corrupt ? DW'(sum_ref - stream_q[5] + (stream_q[5] ^ DW'(1))) : sum_ref;
    corrupt_en = v.corrupt;
    wr_idx = 0; rd_idx = 0; wr_bad = 0; rd_bad = 0; gap_bad = 0; mix_bad = 0;
    sumw = '0; sumr = '0; err_at_done = 1'b0;

    start = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    start = 1'b0;
    check({v.name, "_busy_at_start"}, 64'(busy_o), 64'(1));
    check({v.name, "_err_cleared"}, 64'(err_o), 64'(0));
    #1;
    idx = 0; lat = -1; ndone = 0; lim = 4 * N + 64;
    while (cyc < lim && !(lat >= 0 && cyc >= lat + 4)) begin
      case (v.mode)
        1:       s_valid = (cyc % 2) == 1;
        2:       s_valid = $urandom_range(0, 3) != 0;
        default: s_valid = 1'b1;
      endcase
      s_data = (idx < N) ? stream_q[idx] : DW'($urandom);
      start = (cyc == v.start_at);
      xfer = s_valid && s_ready_o;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (xfer) idx++;
      if (done_o) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc;
          err_at_done = err_o;
          sumw = dut.sum_w_reg;
          sumr = dut.sum_r_reg;
        end
      end
      if (v.abort_at >= 0 && idx == v.abort_at) begin
        #1;
        reset = 1'b1; start = 1'b1; s_valid = 1'b1;
        @(posedge clk); #1;
        check({v.name, "_outputs_zero"},
              64'({en, we, addr, di, s_ready_o, busy_o, done_o, err_o}), 64'(0));
        check({v.name, "_ptrs_zero"}, 64'({dut.wr_ptr_reg, dut.sum_w_reg}), 64'(0));
        #1;
        reset = 1'b0; start = 1'b0; s_valid = 1'b0;
        n_after = 0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (done_o || busy_o) n_after++;
          #1;
        end
        check({v.name, "_idle_no_done"}, 64'(n_after), 64'(0));
        $display("case %s: aborted after %0d transfers", v.name, idx);
        return;
      end
      #1;
    end
    s_valid = 1'b0;

    check({v.name, "_done_count"}, 64'(ndone), 64'(1));
    if (v.exp_lat >= 0) check({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({v.name, "_err_at_done"}, 64'(err_at_done), 64'(v.exp_err));
    check({v.name, "_sum_w"}, 64'(sumw), 64'(sum_ref));
    check({v.name, "_sum_r"}, 64'(sumr), 64'(exp_sum_r));
    check({v.name, "_writes"}, 64'(wr_idx), 64'(N));
    check({v.name, "_reads"}, 64'(rd_idx), 64'(N));
    check({v.name, "_bus_errors"}, 64'(wr_bad + rd_bad + gap_bad + mix_bad), 64'(0));
    check({v.name, "_err_held"}, 64'(err_o), 64'(v.exp_err));
    check({v.name, "_idle"}, 64'(busy_o), 64'(0));
    $display("case %s: done at cycle %0d, writes=%0d reads=%0d err=%0d sum_w=%h",
             v.name, lat, wr_idx, rd_idx, err_at_done, sumw);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, idx0, lw, lat0, nd0;
    bit xfer;

    tbl[0] = '{"full",          0, 1'b0, -1,      -1,  1'b0, 2 * N + 4};
    tbl[1] = '{"backpressure",  1, 1'b0, -1,      -1,  1'b0, 3 * N + 3};
    tbl[2] = '{"random",        2, 1'b0, -1,      -1,  1'b0, -1};
    tbl[3] = '{"corrupt",       0, 1'b1, -1,      -1,  1'b1, 2 * N + 4};
    tbl[4] = '{"ignored_start", 0, 1'b0, N + 100, -1,  1'b0, 2 * N + 4};
    tbl[5] = '{"abort",         0, 1'b0, -1,      300, 1'b0, -1};
    tbl[6] = '{"after_abort",   0, 1'b0, -1,      -1,  1'b0, 2 * N + 4};

    // Reset state of both instances.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({en, we, addr, di, s_ready_o, busy_o, done_o, err_o}), 64'(0));
    check("reset_outputs_v0", 64'({en0, we0, addr0, di0, s_ready0, busy0, done0, err0}), 64'(0));
    #1;
    reset = 1'b0;
    $display("reset: outputs checked");

    for (int t = 0; t < 7; t++) run_case(tbl[t]);

    // VERIFY=0: ramp stream, no reads, done two cycles after the last write.
    wr0_cnt = 0; wr0_bad = 0; rd0_cnt = 0;
    start0 = 1'b1; s_valid0 = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    start0 = 1'b0;
    #1;
    idx0 = 0; lw = -1; lat0 = -1; nd0 = 0;
    while (cyc < 2 * N + 64 && !(lat0 >= 0 && cyc >= lat0 + 4)) begin
      s_data0 = DW'(idx0);
      xfer = s_valid0 && s_ready0;
      @(posedge clk); #1;
      cyc++;
      if (xfer) idx0++;
      if (en0 && we0 && addr0 == AW'(N - 1)) lw = cyc;
      if (done0) begin
        nd0++;
        if (lat0 < 0) lat0 = cyc;
      end
      #1;
    end
    s_valid0 = 1'b0;
    check("v0_latency", 64'(lat0), 64'(N + 3));
    check("v0_done_after_last_write", 64'(lat0 - lw), 64'(2));
    check("v0_done_count", 64'(nd0), 64'(1));
    check("v0_reads", 64'(rd0_cnt), 64'(0));
    check("v0_writes", 64'(wr0_cnt), 64'(N));
    check("v0_write_errors", 64'(wr0_bad), 64'(0));
    check("v0_err", 64'(err0), 64'(0));
    check("v0_lut_last", 64'(lut0[N - 1]), 64'(N - 1));
    $display("case verify0: done at cycle %0d, last write at %0d, writes=%0d reads=%0d",
             lat0, lw, wr0_cnt, rd0_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
